// File: rtl/dwell_locker.sv
// rtl/dwell_locker.sv - Locks a smoothed sample once it persists for DWELL cycles, drops lock after TIMEOUT mismatches.
module dwell_locker #(
    parameter int BUS     = 6,
    parameter int DWELL   = 4,
    parameter int TIMEOUT = 16,
    parameter int CW      = 5
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [BUS-1:0] datain,
    output logic [BUS-1:0] dataout,
    output logic           locked,
    output logic           update
);

    typedef enum logic [1:0] {
        ACQUIRE  = 2'd0,
        LOCKED   = 2'd1,
        CHANGING = 2'd2
    } state_t;

    localparam logic [CW-1:0] RUN_MAX  = CW'(DWELL);
    localparam logic [CW-1:0] RUN_PRE  = CW'(DWELL - 1);
    localparam logic [CW-1:0] LOST_MAX = CW'(TIMEOUT - 1);

    state_t         state_q, state_d;
    logic [BUS-1:0] cand_q, cand_d;
    logic [CW-1:0]  run_q, run_d;
    logic [CW-1:0]  lost_q, lost_d;
    logic [BUS-1:0] dataout_q, dataout_d;
    logic           locked_q, locked_d;
    logic           update_q, update_d;

    logic same;
    logic qualify;
    logic hit;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ACQUIRE;
            cand_q    <= '0;
            run_q     <= '0;
            lost_q    <= '0;
            dataout_q <= '0;
            locked_q  <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            run_q     <= run_d;
            lost_q    <= lost_d;
            dataout_q <= dataout_d;
            locked_q  <= locked_d;
            update_q  <= update_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        run_d     = run_q;
        lost_d    = lost_q;
        dataout_d = dataout_q;
        locked_d  = locked_q;
        update_d  = 1'b0;

        same    = (datain == cand_q);
        qualify = same && (run_q == RUN_PRE);
        hit     = (datain == dataout_q);

        // Run tracking is independent of the lock state.
        if (same) begin
            if (run_q != RUN_MAX) begin
                run_d = run_q + CW'(1);
            end
        end else begin
            cand_d = datain;
            run_d  = CW'(1);
        end

        case (state_q)
            ACQUIRE: begin
                if (qualify) begin
                    dataout_d = datain;
                    locked_d  = 1'b1;
                    update_d  = 1'b1;
                    state_d   = LOCKED;
                end
            end
            LOCKED: begin
                if (hit) begin
                    lost_d = '0;
                end else begin
                    lost_d  = CW'(1);
                    state_d = CHANGING;
                end
            end
            CHANGING: begin
                // Relock is checked before timeout so a coinciding qualify wins.
                if (hit) begin
                    lost_d  = '0;
                    state_d = LOCKED;
                end else if (qualify) begin
                    dataout_d = datain;
                    update_d  = 1'b1;
                    lost_d    = '0;
                    state_d   = LOCKED;
                end else if (lost_q == LOST_MAX) begin
                    locked_d = 1'b0;
                    lost_d   = '0;
                    state_d  = ACQUIRE;
                end else begin
                    lost_d = lost_q + CW'(1);
                end
            end
            default: begin
                state_d  = ACQUIRE;
                locked_d = 1'b0;
                lost_d   = '0;
            end
        endcase
    end

    assign dataout = dataout_q;
    assign locked  = locked_q;
    assign update  = update_q;

endmodule

// File: tb/tb_dwell_locker.sv
// tb/tb_dwell_locker.sv - Directed and randomized checks of dwell_locker against a sample-history model.
module tb_dwell_locker;

    localparam int BUS     = 6;
    localparam int DWELL   = 4;
    localparam int TIMEOUT = 16;

    logic           clock;
    logic           reset;
    logic [BUS-1:0] datain;
    logic [BUS-1:0] dataout;
    logic           locked;
    logic           update;

    int checks = 0;
    int errors = 0;

    logic [BUS-1:0] hist[$];
    logic           m_locked;
    logic [BUS-1:0] m_out;
    logic           m_upd;
    int             m_miss;
    int             upd_count;

    dwell_locker #(.BUS(BUS), .DWELL(DWELL), .TIMEOUT(TIMEOUT), .CW(5)) dut (
        .clock  (clock),
        .reset  (reset),
        .datain (datain),
        .dataout(dataout),
        .locked (locked),
        .update (update)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int trailing_equal();
        int n = 0;
        for (int i = hist.size() - 1; i >= 0; i--) begin
            if (hist[i] != hist[hist.size() - 1]) break;
            n++;
        end
        return n;
    endfunction

    // Model: a sample qualifies when exactly DWELL identical samples end the history since reset.
    task automatic model_edge(input logic [BUS-1:0] x);
        logic q;
        hist.push_back(x);
        if (hist.size() > DWELL + 2) void'(hist.pop_front());
        q = (trailing_equal() == DWELL);
        m_upd = 1'b0;
        if (!m_locked) begin
            if (q) begin
                m_out = x; m_locked = 1'b1; m_upd = 1'b1;
            end
        end else if (x == m_out) begin
            m_miss = 0;
        end else if (q) begin
            m_out = x; m_upd = 1'b1; m_miss = 0;
        end else if (m_miss + 1 == TIMEOUT) begin
            m_locked = 1'b0; m_miss = 0;
        end else begin
            m_miss++;
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ".dataout"}, 32'(dataout), 32'(m_out));
        chk({tag, ".locked"},  32'(locked),  32'(m_locked));
        chk({tag, ".update"},  32'(update),  32'(m_upd));
        if (update === 1'b1) upd_count++;
    endtask

    task automatic tick(input logic [BUS-1:0] x, input string tag);
        datain = x;
        @(posedge clock);
        model_edge(x);
        #1;
        compare_all(tag);
    endtask

    task automatic do_reset(input logic [BUS-1:0] x);
        datain = x;
        reset  = 1'b1;
        @(posedge clock);
        hist.delete();
        m_locked = 1'b0; m_out = '0; m_upd = 1'b0; m_miss = 0;
        #1;
        compare_all("reset");
        reset = 1'b0;
    endtask

    task automatic lock_on(input logic [BUS-1:0] v);
        do_reset(v);
        for (int i = 0; i < DWELL; i++) tick(v, "lock_on");
    endtask

    initial begin
        logic [BUS-1:0] cur;
        reset = 1'b1;
        datain = '0;
        upd_count = 0;
        repeat (2) @(posedge clock);

        // 1: acquisition latency and single-cycle strobe
        do_reset(6'd5);
        upd_count = 0;
        for (int i = 0; i < DWELL; i++) tick(6'd5, "t1");
        chk("t1.dataout", 32'(dataout), 32'd5);
        chk("t1.update_hi", 32'(update), 32'd1);
        tick(6'd5, "t1b");
        chk("t1.update_lo", 32'(update), 32'd0);
        for (int i = 0; i < 5; i++) tick(6'd5, "t1c");
        chk("t1.update_count", 32'(upd_count), 32'd1);

        // 2: short excursion is absorbed
        lock_on(6'd5);
        upd_count = 0;
        for (int i = 0; i < 3; i++) tick(6'd9, "t2");
        tick(6'd5, "t2b");
        chk("t2.dataout", 32'(dataout), 32'd5);
        chk("t2.locked", 32'(locked), 32'd1);
        chk("t2.no_update", 32'(upd_count), 32'd0);

        // 3: move the lock
        lock_on(6'd5);
        upd_count = 0;
        for (int i = 0; i < DWELL; i++) tick(6'd9, "t3");
        chk("t3.dataout", 32'(dataout), 32'd9);
        chk("t3.update_count", 32'(upd_count), 32'd1);

        // 4: timeout then re-acquire
        lock_on(6'd5);
        upd_count = 0;
        for (int i = 0; i < TIMEOUT; i++) tick((i % 2 == 0) ? 6'd9 : 6'd10, "t4");
        chk("t4.locked", 32'(locked), 32'd0);
        chk("t4.dataout", 32'(dataout), 32'd5);
        chk("t4.no_update", 32'(upd_count), 32'd0);
        for (int i = 0; i < DWELL; i++) tick(6'd7, "t4b");
        chk("t4.relocked", 32'(locked), 32'd1);
        chk("t4.newval", 32'(dataout), 32'd7);
        chk("t4.update", 32'(update), 32'd1);

        // 5: relock coinciding with timeout wins
        lock_on(6'd5);
        for (int i = 0; i < 12; i++) tick((i % 2 == 0) ? 6'd9 : 6'd10, "t5");
        for (int i = 0; i < DWELL; i++) tick(6'd9, "t5b");
        chk("t5.dataout", 32'(dataout), 32'd9);
        chk("t5.locked", 32'(locked), 32'd1);
        chk("t5.update", 32'(update), 32'd1);

        // 6: reset mid-change, then re-acquire on value 0
        lock_on(6'd5);
        for (int i = 0; i < 6; i++) tick((i % 2 == 0) ? 6'd9 : 6'd10, "t6");
        do_reset(6'd0);
        chk("t6.rst_dataout", 32'(dataout), 32'd0);
        chk("t6.rst_locked", 32'(locked), 32'd0);
        upd_count = 0;
        for (int i = 0; i < DWELL; i++) tick(6'd0, "t6b");
        chk("t6.locked", 32'(locked), 32'd1);
        chk("t6.update", 32'(update), 32'd1);
        tick(6'd0, "t6c");
        chk("t6.update_count", 32'(upd_count), 32'd1);

        // 7: re-acquire on same value after timeout still strobes
        lock_on(6'd5);
        for (int i = 0; i < TIMEOUT; i++) tick((i % 2 == 0) ? 6'd9 : 6'd10, "t7");
        for (int i = 0; i < DWELL; i++) tick(6'd5, "t7b");
        chk("t7.same_val_update", 32'(update), 32'd1);

        // Random phase: sticky values from a small alphabet plus occasional resets
        cur = 6'd5;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(cur);
            end else begin
                case ($urandom_range(0, 9))
                    0: cur = 6'd5;
                    1: cur = 6'd9;
                    2: cur = 6'd10;
                    3: cur = 6'($urandom);
                    default: ;
                endcase
                tick(cur, "rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dwell_locker.md
Name: dwell_locker

Overview:
- Sits directly downstream of the 6-bit smoother on the direction-estimate path.
- Consumes the smoothed value and declares a value "locked" only after it has persisted for DWELL consecutive cycles.
- Holds the locked value through short excursions. Drops lock if the input stays away from the locked value for TIMEOUT cycles without a new value qualifying.
- Emits a one-cycle update strobe to the reporting logic on every lock acquisition or locked-value change.

Parameters:
- bus, 6, data width of datain/dataout.
- dwell, 4, consecutive equal samples required to acquire or move the lock.
- timeout, 16, consecutive samples differing from dataout (while locked) before lock is dropped.
- cw, 5, width of the internal run and lost counters.
- Legal range: 2 <= dwell < timeout <= 2^cw - 1.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- datain  input  bus  smoothed sample, one per clock.
- dataout  output  bus  last locked value; held when lock is lost.
- locked  output  1  high while a valid lock is held.
- update  output  1  one-cycle strobe: locked rose, or dataout changed while locked.

Behaviour:
- Clocking: one clock, synchronous active-high reset, named clock and reset.
- Reset: dataout=0, locked=0, update=0, candidate=0, run=0, lost=0, state=ACQUIRE. Reset has priority over everything and may be asserted in any state; the next cycle starts a fresh acquisition.
- Run tracking, every non-reset edge, all states:
  - If datain==candidate: run <= min(run+1, dwell).
  - Else: candidate <= datain, run <= 1.
  - A sample "qualifies" on the edge where datain==candidate and run==dwell-1, i.e. the edge sampling the dwell-th consecutive equal value.
- State encoding: 2-bit state register.
- ACQUIRE (locked=0):
  - On a qualifying edge: dataout <= datain, locked <= 1, update <= 1, go LOCKED.
  - Otherwise dataout holds.
- LOCKED:
  - datain==dataout: stay, lost <= 0.
  - datain!=dataout: lost <= 1, go CHANGING.
- CHANGING (locked=1, dataout held):
  - Qualifying edge with datain!=dataout: dataout <= datain, update <= 1, lost <= 0, go LOCKED.
  - datain==dataout: lost <= 0, go LOCKED, no update.
  - datain!=dataout and lost==timeout-1 with no qualifying edge: locked <= 0, lost <= 0, go ACQUIRE; dataout keeps the last value; no update.
  - Otherwise: lost <= lost+1.
- Simultaneous events: a qualifying edge and timeout on the same edge resolve as relock. dataout takes the new value, locked stays 1, update=1.
- update: registered and high for exactly one cycle after the triggering edge; 0 on all other cycles.
- update on re-acquire: re-acquisition after a timeout pulses update even if the new value equals the old dataout.
- Latency: a new value first sampled at edge k appears on dataout after edge k+dwell-1 (the dwell-th sample edge).
- Saturation: run saturates at dwell. lost never exceeds timeout-1.

Test Plan (dwell=4, timeout=16, bus=6):
1. Reset, then datain=5 held → after 4th edge dataout=5, locked=1, update=1 for exactly one cycle; 0 thereafter.
2. Locked on 5; datain=9 for 3 edges, then 5 → dataout stays 5, locked=1, update never asserts, state back to LOCKED.
3. Locked on 5; datain=9 held → after 4th edge of 9, dataout=9, update pulses once, locked stays 1.
4. Locked on 5; datain alternates 9,10 for 16 edges → after 16th edge locked=0, dataout=5, no update. Then datain=7 for 4 edges → locked=1, dataout=7, update pulse.
5. Locked on 5; datain alternates 9,10 for 12 edges, then 9 for 4 edges (16th mismatch coincides with qualification) → relock wins: dataout=9, locked=1, update=1.
6. In CHANGING with lost=6, assert reset for one cycle, then hold datain=0 → dataout=0, locked=0 immediately after reset. After 4 edges of 0: locked=1, dataout=0, update pulses once.
